// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - 8x8 register memory built from per-bit storage cells
module memory_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic d,
  output logic q
);

  logic bit_d;
  logic bit_q;

  // Next bit: take the bus bit when this word is being written, else hold
  always_comb begin
    bit_d = bit_q;
    if (load) begin
      bit_d = d;
    end
  end

  // Single storage bit, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q = bit_q;

endmodule

module memory_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op,
  input  logic              sel,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in_bus,
  output logic [DATA_W-1:0] out_bus,
  output logic [DATA_W-1:0] stored_value
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  word_load;
  logic [DATA_W-1:0] mem_word [DEPTH];
  logic [DATA_W-1:0] out_bus_d;
  logic [DATA_W-1:0] out_bus_q;

  // Write strobe per word: enabled write access decoded against the address
  always_comb begin
    word_load = '0;
    if (sel && op) begin
      word_load[address] = 1'b1;
    end
  end

  // 64 bit cells arranged as DEPTH words of DATA_W bits
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
      memory_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (word_load[w]),
        .d     (in_bus[b]),
        .q     (mem_word[w][b])
      );
    end
  end

  // Read data is only presented for the cycle after an enabled read
  always_comb begin
    out_bus_d = '0;
    if (sel && !op) begin
      out_bus_d = mem_word[address];
    end
  end

  // Registered read port, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bus_q <= '0;
    end else begin
      out_bus_q <= out_bus_d;
    end
  end

  assign out_bus      = out_bus_q;
  assign stored_value = mem_word[address];

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - directed self-checking bench for memory_unit
module tb_memory_unit;

  logic       clk;
  logic       rst_n;
  logic       op;
  logic       sel;
  logic [2:0] address;
  logic [7:0] in_bus;
  logic [7:0] out_bus;
  logic [7:0] stored_value;

  int check_cnt;
  int error_cnt;

  logic [7:0] exp_mem [8];

  memory_unit #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .sel          (sel),
    .address      (address),
    .in_bus       (in_bus),
    .out_bus      (out_bus),
    .stored_value (stored_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    check_cnt++;
    if (act !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic o, input logic s, input logic [2:0] a, input logic [7:0] d);
    op      = o;
    sel     = s;
    address = a;
    in_bus  = d;
  endtask

  initial begin
    check_cnt = 0;
    error_cnt = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    #23;
    check("reset_out", out_bus, 8'h00);
    check("reset_stored", stored_value, 8'h00);
    rst_n = 1'b1;
    #2;

    // Write blocked by sel=0
    drive(1'b1, 1'b0, 3'd0, 8'h55);
    tick();
    check("blocked_stored", stored_value, 8'h00);
    check("blocked_out", out_bus, 8'h00);

    // Write then read address 0
    drive(1'b1, 1'b1, 3'd0, 8'h55);
    tick();
    check("wr0_stored", stored_value, 8'h55);
    check("wr0_out", out_bus, 8'h00);
    drive(1'b0, 1'b1, 3'd0, 8'h00);
    tick();
    check("rd0_out", out_bus, 8'h55);
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    check("idle_out", out_bus, 8'h00);
    check("idle_stored", stored_value, 8'h55);

    // Address isolation
    drive(1'b1, 1'b1, 3'd5, 8'hA3);
    tick();
    drive(1'b1, 1'b1, 3'd2, 8'h3C);
    tick();
    drive(1'b0, 1'b1, 3'd5, 8'h00);
    tick();
    check("rd5_out", out_bus, 8'hA3);
    drive(1'b0, 1'b1, 3'd2, 8'h00);
    tick();
    check("rd2_out", out_bus, 8'h3C);
    drive(1'b0, 1'b1, 3'd0, 8'h00);
    tick();
    check("rd0_again", out_bus, 8'h55);
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    exp_mem = '{8'h55, 8'h00, 8'h3C, 8'h00, 8'h00, 8'hA3, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      check($sformatf("stored_addr%0d", i), stored_value, exp_mem[i]);
    end
    tick();

    // Back-to-back write/read on address 7
    drive(1'b1, 1'b1, 3'd7, 8'hFF);
    tick();
    drive(1'b0, 1'b1, 3'd7, 8'h00);
    tick();
    check("b2b_rd_ff", out_bus, 8'hFF);
    drive(1'b1, 1'b1, 3'd7, 8'h01);
    tick();
    check("b2b_wr_out", out_bus, 8'h00);
    drive(1'b0, 1'b1, 3'd7, 8'h00);
    tick();
    check("b2b_rd_01", out_bus, 8'h01);
    check("b2b_stored", stored_value, 8'h01);

    // Reset asserted mid-cycle during a read of a non-zero word
    drive(1'b0, 1'b1, 3'd5, 8'h00);
    tick();
    check("pre_rst_out", out_bus, 8'hA3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", out_bus, 8'h00);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #0.5;
      check($sformatf("rst_stored%0d", i), stored_value, 8'h00);
    end
    address = 3'd5;
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_rd", out_bus, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
